// File: rtl/cmp_share_seq.sv
// cmp_share_seq: shared, sequenced magnitude/equality compare unit.
//
// NREQ requesters are served by one chunked comparator. A round-robin
// arbiter picks the next requester. The operands are then scanned MSB-first,
// CHUNK bits per cycle. The scan stops on the first chunk that differs. The
// result is returned as an all-ones or all-zeros mask, tagged with the
// requester id.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that transfer. It may withdraw valid before a transfer. It
// must never derive valid from ready, because req_ready is combinational
// from req_valid.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]       per-requester request valid
//   req_ready  out  [NREQ]       per-requester accept, one-hot or zero
//   req_a      in   [NREQ*XLEN]  operand a, requester i at [i*XLEN +: XLEN]
//   req_b      in   [NREQ*XLEN]  operand b, same packing
//   req_op     in   [NREQ*2]     00 SLT, 01 SLTU, 10 SEQ, 11 SGE
//   resp_valid out  result valid
//   resp_ready in   consumer accept
//   resp_data  out  [XLEN]  all-ones if the condition holds, else zero
//   resp_id    out  [IDW]   requester that owns resp_data
//   busy       out  high whenever the FSM is not IDLE
module cmp_share_seq #(
  parameter int NREQ  = 2,
  parameter int XLEN  = 32,
  parameter int CHUNK = 8,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*2-1:0]    req_op,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [XLEN-1:0]      resp_data,
  output logic [IDW-1:0]       resp_id,
  output logic                 busy
);

  localparam int NCHUNK = XLEN / CHUNK;
  localparam int CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [1:0]      op_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  rr_q;
  logic [CIW-1:0]  cidx_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;

  logic            grant_vld;
  logic [IDW-1:0]  grant;
  int              grant_idx;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [1:0]      sel_op;
  logic            sel_signed;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;

  // Map the raw lt/eq outcome to the requested condition.
  function automatic logic map_result(input logic [1:0] op, input logic lt,
                                      input logic eq);
    logic r;
    case (op)
      OP_SLT, OP_SLTU: r = lt;
      OP_SEQ:          r = eq;
      default:         r = ~lt;  // SGE
    endcase
    return r;
  endfunction

  // Round-robin search. It starts one past the last granted requester, so
  // the requester served most recently gets the lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    grant_idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      grant_idx = int'(rr_q) + k;
      if (grant_idx >= NREQ) grant_idx = grant_idx - NREQ;
      if (!grant_vld && req_valid[grant_idx]) begin
        grant_vld = 1'b1;
        grant     = IDW'(grant_idx);
      end
    end
  end

  // req_ready is gated by rst_n so that it drops asynchronously with reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == S_IDLE && grant_vld) req_ready[grant] = 1'b1;
  end

  always_comb begin
    sel_a      = req_a[int'(grant)*XLEN +: XLEN];
    sel_b      = req_b[int'(grant)*XLEN +: XLEN];
    sel_op     = req_op[int'(grant)*2 +: 2];
    // SLT (00) and SGE (11) are the signed ops.
    sel_signed = (sel_op == OP_SLT) || (sel_op == 2'b11);
    chunk_a    = a_q[int'(cidx_q)*CHUNK +: CHUNK];
    chunk_b    = b_q[int'(cidx_q)*CHUNK +: CHUNK];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= '0;
      rr_q         <= IDW'(NREQ - 1);
      cidx_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            id_q <= grant;
            rr_q <= grant;
            // With differing signs, the negative operand is the smaller one.
            // No scan is needed in that case.
            if (sel_signed && (sel_a[XLEN-1] != sel_b[XLEN-1])) begin
              resp_data_q  <= {XLEN{map_result(sel_op, sel_a[XLEN-1], 1'b0)}};
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end else begin
              cidx_q  <= CIW'(NCHUNK - 1);
              state_q <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          // An unsigned chunk compare is correct here. The signs are equal
          // whenever a signed op reaches this state.
          if (chunk_a != chunk_b) begin
            resp_data_q  <= {XLEN{map_result(op_q, chunk_a < chunk_b, 1'b0)}};
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else if (cidx_q == '0) begin
            resp_data_q  <= {XLEN{map_result(op_q, 1'b0, 1'b1)}};
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            cidx_q <= cidx_q - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = id_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cmp_share_seq.sv
// Testbench for cmp_share_seq: directed vector table, round-robin, stall and
// reset sequences, then randomized traffic against a reference model.
module tb_cmp_share_seq;

  localparam int NREQ   = 2;
  localparam int XLEN   = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = XLEN / CHUNK;
  localparam int IDW    = 1;

  localparam logic [1:0] OP_SLT  = 2'b00;
  localparam logic [1:0] OP_SLTU = 2'b01;
  localparam logic [1:0] OP_SEQ  = 2'b10;
  localparam logic [1:0] OP_SGE  = 2'b11;

  logic                 clk;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_a;
  logic [NREQ*XLEN-1:0] req_b;
  logic [NREQ*2-1:0]    req_op;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [XLEN-1:0]      resp_data;
  logic [IDW-1:0]       resp_id;
  logic                 busy;

  cmp_share_seq #(.NREQ(NREQ), .XLEN(XLEN), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN:0] exp_q[$];  // {id, data}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [XLEN-1:0] ref_data(input logic [1:0] op,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic r;
    case (op)
      OP_SLT:  r = ($signed(a) < $signed(b));
      OP_SLTU: r = (a < b);
      OP_SEQ:  r = (a == b);
      default: r = ($signed(a) >= $signed(b));
    endcase
    return {XLEN{r}};
  endfunction

  // Cycles from accept to resp_valid. Sign-differing signed ops take 1.
  // Otherwise it is one more than the number of chunks read, counting down
  // from the top to the chunk that holds the highest differing bit.
  function automatic int ref_lat(input logic [1:0] op, input logic [XLEN-1:0] a,
                                 input logic [XLEN-1:0] b);
    logic [XLEN-1:0] d;
    int msb;
    d = a ^ b;
    if ((op == OP_SLT || op == OP_SGE) && (a[XLEN-1] != b[XLEN-1])) return 1;
    if (d == '0) return NCHUNK + 1;
    msb = 0;
    for (int i = 0; i < XLEN; i++) if (d[i]) msb = i;
    return (XLEN - 1 - msb) / CHUNK + 2;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    req_a[i*XLEN +: XLEN] = a;
    req_b[i*XLEN +: XLEN] = b;
    req_op[i*2 +: 2]      = op;
  endtask

  typedef struct {
    int              id;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp_data;
    int              exp_lat;
  } vec_t;

  vec_t tbl[9];

  // Issue one request from a single requester. Entered just after a rising
  // edge with the DUT idle. Returns just after the response handshake edge.
  task automatic run_vec(input vec_t v, input int n);
    int cyc;
    set_req(v.id, v.op, v.a, v.b);
    req_valid       = '0;
    req_valid[v.id] = 1'b1;
    resp_ready      = 1'b1;
    #1;
    cyc = 0;
    while (!req_ready[v.id] && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk($sformatf("vec%0d_ready", n), 64'(req_ready[v.id]), 64'd1);
    @(posedge clk); #1;
    req_valid = '0;
    cyc = 1;
    while (!resp_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    chk($sformatf("vec%0d_lat", n), 64'(cyc), 64'(v.exp_lat));
    chk($sformatf("vec%0d_data", n), 64'(resp_data), 64'(v.exp_data));
    chk($sformatf("vec%0d_id", n), 64'(resp_id), 64'(v.id));
    @(posedge clk); #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int ngr;
    int g_exp;
    int cyc;
    bit any_resp;
    int m_rr;
    bit m_busy;
    bit seen;
    bit stuck;
    int acc_cyc;
    int exp_lat;
    bit acc[NREQ];
    bit raise_ok;
    int g;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;
    logic [1:0] rop;
    logic [NREQ-1:0] exp_ready;

    tbl[0] = '{0, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1};
    tbl[1] = '{0, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2};
    tbl[2] = '{1, OP_SEQ,  32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 5};
    tbl[3] = '{1, OP_SEQ,  32'h1234_5678, 32'h1234_5679, 32'h0000_0000, 5};
    tbl[4] = '{1, OP_SGE,  32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 5};
    tbl[5] = '{0, OP_SGE,  32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 1};
    tbl[6] = '{1, OP_SLT,  32'h0001_0000, 32'h0002_0000, 32'hFFFF_FFFF, 3};
    tbl[7] = '{0, OP_SLTU, 32'h0000_00FF, 32'h0000_0100, 32'hFFFF_FFFF, 4};
    tbl[8] = '{1, OP_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5};

    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_op     = '0;
    resp_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = '1;
    #1;
    chk("rst_ready_gated", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Round robin after reset: both requesters valid all the time.
    set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    set_req(1, OP_SLT, 32'h0000_0001, 32'hFFFF_FFFF);
    req_valid  = '1;
    resp_ready = 1'b1;
    #1;
    ngr = 0;
    g_exp = 0;
    for (int c = 0; c < 60; c++) begin
      if (req_ready != '0 && ngr < 4) begin
        chk("rr_grant", 64'(req_ready), 64'(1 << g_exp));
        exp_q.push_back({g_exp[0], ref_data(req_op[g_exp*2 +: 2],
                         req_a[g_exp*XLEN +: XLEN], req_b[g_exp*XLEN +: XLEN])});
        g_exp = g_exp ^ 1;
        ngr++;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("rr_unexpected_resp", 64'd1, 64'd0);
        else chk("rr_resp", 64'({resp_id, resp_data}), 64'(exp_q.pop_front()));
      end
      @(posedge clk); #1;
      if (ngr == 4) req_valid = '0;
      #1;
      if (ngr == 4 && exp_q.size() == 0 && !busy) break;
    end
    chk("rr_count", 64'(ngr), 64'd4);
    chk("rr_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Table of directed vectors
    for (int i = 0; i < 9; i++) run_vec(tbl[i], i);

    // Response stall: resp_ready low for 3 cycles while req1 waits.
    set_req(0, OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    set_req(1, OP_SEQ, 32'h0000_0005, 32'h0000_0005);
    resp_ready = 1'b0;
    req_valid  = 2'b01;
    #1;
    chk("stall_grant", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = 2'b10;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 64'(resp_valid), 64'd1);
      chk("stall_data", 64'(resp_data), 64'hFFFF_FFFF);
      chk("stall_id", 64'(resp_id), 64'd0);
      chk("stall_ready", 64'(req_ready), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
      @(posedge clk); #2;
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    chk("stall_valid_fall", 64'(resp_valid), 64'd0);
    chk("stall_idle", 64'(busy), 64'd0);
    chk("stall_next_grant", 64'(req_ready), 64'b10);
    @(posedge clk); #1;
    req_valid = '0;
    #1;
    chk("stall_next_busy", 64'(busy), 64'd1);
    cyc = 0;
    while (!resp_valid && cyc < 10) begin
      @(posedge clk); #1; cyc++;
    end
    chk("stall_next_data", 64'(resp_data), 64'hFFFF_FFFF);
    chk("stall_next_id", 64'(resp_id), 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a scan.
    set_req(0, OP_SEQ, 32'hAAAA_5555, 32'hAAAA_5555);
    req_valid = 2'b01;
    #1;
    chk("mid_grant", 64'(req_ready), 64'b01);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    set_req(1, OP_SLTU, 32'h0000_0001, 32'h0000_0002);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_data", 64'(resp_data), 64'd0);
    chk("mid_rst_id", 64'(resp_id), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    any_resp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      if (resp_valid || busy) any_resp = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("post_rst_grant", 64'(req_ready), 64'b01);
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (resp_valid) any_resp = 1'b1;
    end
    chk("mid_rst_no_resp", 64'(any_resp), 64'd0);

    // Randomized traffic against the model.
    m_rr = NREQ - 1;
    m_busy = 1'b0;
    seen = 1'b0;
    stuck = 1'b0;
    acc_cyc = 0;
    exp_lat = 0;
    for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 3000 && !stuck; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          acc[i] = 1'b0;
          req_valid[i] = 1'b0;
          raise_ok = 1'b1;
        end else begin
          raise_ok = !req_valid[i];
          if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end
        if (raise_ok && $urandom_range(0, 2) != 0) begin
          ra  = $urandom;
          rop = 2'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0:       rb = ra;
            1:       rb = ra ^ (32'd1 << $urandom_range(0, XLEN - 1));
            2:       rb = $urandom;
            default: rb = ra ^ (32'($urandom_range(1, 255)) << (8 * $urandom_range(0, 3)));
          endcase
          set_req(i, rop, ra, rb);
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (!m_busy) begin
        g = -1;
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
        chk("rnd_idle_busy", 64'(busy), 64'd0);
        chk("rnd_idle_valid", 64'(resp_valid), 64'd0);
        if (g >= 0) begin
          acc[g] = 1'b1;
          m_rr = g;
          exp_q.push_back({g[0], ref_data(req_op[g*2 +: 2], req_a[g*XLEN +: XLEN],
                                          req_b[g*XLEN +: XLEN])});
          exp_lat = ref_lat(req_op[g*2 +: 2], req_a[g*XLEN +: XLEN], req_b[g*XLEN +: XLEN]);
          acc_cyc = c;
          m_busy = 1'b1;
          seen = 1'b0;
        end
      end else begin
        chk("rnd_busy_ready", 64'(req_ready), 64'd0);
        chk("rnd_busy", 64'(busy), 64'd1);
        if (resp_valid) begin
          if (!seen) begin
            chk("rnd_lat", 64'(c - acc_cyc), 64'(exp_lat));
            seen = 1'b1;
          end
          if (exp_q.size() == 0) chk("rnd_unexpected_resp", 64'd1, 64'd0);
          else chk("rnd_resp", 64'({resp_id, resp_data}), 64'(exp_q[0]));
          if (resp_ready) begin
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            m_busy = 1'b0;
          end
        end else if (c - acc_cyc > NCHUNK + 2) begin
          chk("rnd_timeout", 64'd0, 64'd1);
          stuck = 1'b1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
